// File: rtl/hazard_detect_unit.sv
// Pipeline hazard detection: load-use interlock, HI/LO interlock while the
// multiply/divide unit is occupied, and a saturating stall-cycle counter.
module hazard_detect_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IDRs,
  input  logic [4:0]  IDRt,
  input  logic        IDUsesRs,
  input  logic        IDUsesRt,
  input  logic        IDReadsHiLo,
  input  logic        IDIsMulDiv,
  input  logic        EXMemRead,
  input  logic [4:0]  EXRt,
  input  logic        EXStartMul,
  input  logic        EXStartDiv,
  input  logic        BranchHappen,
  input  logic        StallCountClr,
  output logic        HazardHappen,
  output logic        LoadUseHazard,
  output logic        HiLoHazard,
  output logic        MulDivBusy,
  output logic [15:0] StallCount
);

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY} state_t;

  state_t     state, nextState;
  logic [7:0] cnt, nextCnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // Starts are only honoured from IDLE; divide wins a simultaneous start.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    case (state)
      IDLE: begin
        if (EXStartDiv) begin
          nextState = DIV_BUSY;
          nextCnt   = 8'(DIV_CYCLES - 1);
        end else if (EXStartMul) begin
          nextState = MUL_BUSY;
          nextCnt   = 8'(MUL_CYCLES - 1);
        end
      end
      MUL_BUSY, DIV_BUSY: begin
        if (cnt == 8'd0) nextState = IDLE;
        else             nextCnt   = cnt - 8'd1;
      end
      default: nextState = IDLE;
    endcase
  end

  assign MulDivBusy    = (state != IDLE);
  assign LoadUseHazard = EXMemRead && (EXRt != 5'd0) &&
                         ((IDUsesRs && (IDRs == EXRt)) || (IDUsesRt && (IDRt == EXRt)));
  assign HiLoHazard    = MulDivBusy && (IDReadsHiLo || IDIsMulDiv);
  assign HazardHappen  = LoadUseHazard || HiLoHazard;

  // Flushed cycles are not counted as stalls; counter saturates.
  always_ff @(posedge clk) begin
    if (!rst_n)
      StallCount <= 16'd0;
    else if (StallCountClr)
      StallCount <= 16'd0;
    else if (HazardHappen && !BranchHappen && (StallCount != 16'hFFFF))
      StallCount <= StallCount + 16'd1;
  end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed self-checking bench for hazard_detect_unit (default parameters).
module tb_hazard_detect_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  IDRs, IDRt, EXRt;
  logic        IDUsesRs, IDUsesRt, IDReadsHiLo, IDIsMulDiv;
  logic        EXMemRead, EXStartMul, EXStartDiv, BranchHappen, StallCountClr;
  logic        HazardHappen, LoadUseHazard, HiLoHazard, MulDivBusy;
  logic [15:0] StallCount;

  int checks = 0;
  int failures = 0;
  int n;

  hazard_detect_unit dut (
    .clk(clk), .rst_n(rst_n),
    .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
    .IDReadsHiLo(IDReadsHiLo), .IDIsMulDiv(IDIsMulDiv),
    .EXMemRead(EXMemRead), .EXRt(EXRt),
    .EXStartMul(EXStartMul), .EXStartDiv(EXStartDiv),
    .BranchHappen(BranchHappen), .StallCountClr(StallCountClr),
    .HazardHappen(HazardHappen), .LoadUseHazard(LoadUseHazard),
    .HiLoHazard(HiLoHazard), .MulDivBusy(MulDivBusy), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    IDRs = 5'd0; IDRt = 5'd0; EXRt = 5'd0;
    IDUsesRs = 0; IDUsesRt = 0; IDReadsHiLo = 0; IDIsMulDiv = 0;
    EXMemRead = 0; EXStartMul = 0; EXStartDiv = 0;
    BranchHappen = 0; StallCountClr = 0;
  endtask

  initial begin
    idleInputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    #1;
    chk("rst_busy", MulDivBusy, 0);
    chk("rst_count", StallCount, 0);
    chk("rst_hazard", HazardHappen, 0);

    // load-use, purely combinational (no edges taken)
    EXMemRead = 1; EXRt = 5'd8; IDRs = 5'd8; IDUsesRs = 1; #1;
    chk("lu_rs", LoadUseHazard, 1);
    chk("lu_rs_hz", HazardHappen, 1);
    EXRt = 5'd0; IDRs = 5'd0; #1;
    chk("lu_r0", LoadUseHazard, 0);
    chk("lu_r0_hz", HazardHappen, 0);
    EXRt = 5'd8; IDRs = 5'd8; IDUsesRs = 0; #1;
    chk("lu_norsuse", LoadUseHazard, 0);
    chk("lu_norsuse_hz", HazardHappen, 0);
    IDUsesRt = 1; IDRt = 5'd8; #1;
    chk("lu_rt", LoadUseHazard, 1);
    EXMemRead = 0; #1;
    chk("lu_noload", LoadUseHazard, 0);
    idleInputs(); #1;

    // multiply: busy t+1..t+4, HI/LO hazard only while busy
    IDReadsHiLo = 1; EXStartMul = 1; #1;
    chk("mul_t_busy", MulDivBusy, 0);
    chk("mul_t_hilo", HiLoHazard, 0);
    tick();
    EXStartMul = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("mul_busy_%0d", i), MulDivBusy, 1);
      chk($sformatf("mul_hilo_%0d", i), HiLoHazard, 1);
      tick();
    end
    chk("mul_t5_busy", MulDivBusy, 0);
    chk("mul_t5_hilo", HiLoHazard, 0);
    chk("mul_stalls", StallCount, 4);
    IDReadsHiLo = 0; StallCountClr = 1; tick();
    StallCountClr = 0;
    chk("clr", StallCount, 0);

    // simultaneous start -> divide; restart attempt at busy cycle 10 ignored
    EXStartMul = 1; EXStartDiv = 1; tick();
    EXStartMul = 0; EXStartDiv = 0;
    n = 0;
    while (MulDivBusy && n < 100) begin
      n++;
      if (n == 1) begin
        IDIsMulDiv = 1; #1;
        chk("div_muldiv_hz", HiLoHazard, 1);
        IDIsMulDiv = 0;
      end
      EXStartMul = (n == 10); EXStartDiv = (n == 10);
      tick();
      EXStartMul = 0; EXStartDiv = 0;
    end
    chk("div_busy_cycles", n, 32);
    chk("div_no_stall", StallCount, 0);

    // counter: 3 stalls, then a flushed stall cycle not counted
    EXMemRead = 1; EXRt = 5'd3; IDRt = 5'd3; IDUsesRt = 1;
    tick(); tick(); tick();
    BranchHappen = 1; tick();
    BranchHappen = 0;
    chk("cnt_branch", StallCount, 3);
    StallCountClr = 1; tick();
    StallCountClr = 0;
    chk("cnt_clr_prio", StallCount, 0);
    idleInputs(); #1;

    // reset mid-divide, start ignored during reset
    EXStartDiv = 1; tick();
    EXStartDiv = 0; IDReadsHiLo = 1;
    tick(); tick(); tick(); tick();
    chk("rd_busy5", MulDivBusy, 1);
    chk("rd_cnt_pre", StallCount, 4);
    rst_n = 0; EXStartDiv = 1; tick();
    rst_n = 1; EXStartDiv = 0; IDReadsHiLo = 0; #1;
    chk("rd_busy_after", MulDivBusy, 0);
    chk("rd_cnt_after", StallCount, 0);
    EXStartMul = 1; tick();
    EXStartMul = 0;
    n = 0;
    while (MulDivBusy && n < 100) begin
      n++;
      tick();
    end
    chk("rd_mul_cycles", n, 4);

    // saturation
    EXMemRead = 1; EXRt = 5'd9; IDRs = 5'd9; IDUsesRs = 1;
    repeat (65535) tick();
    chk("sat_reach", StallCount, 16'hFFFF);
    tick();
    chk("sat_hold", StallCount, 16'hFFFF);
    idleInputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
